score_accum10: RTL and testbench

Frame-based score accumulator that sits directly upstream of the 10-way argmax classifier stage. It accepts a stream of beats, each carrying one unsigned partial score per class, and sums them per class over a frame with saturation. At frame end it presents the 10 totals as a stable `bids` vector plus a `win_valid` strobe aligned to the argmax stage's registered winner. Accumulation, framing, handshake and error status are all handled here, so the argmax stage stays purely compare-and-register.

---
 rtl/score_accum10_pkg.sv | 17 +
 rtl/score_accum10_sat_add.sv | 25 ++
 rtl/score_accum10.sv | 149 ++++++++++++++
 tb/tb_score_accum10.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_accum10_pkg.sv
// Shared types and helpers for the frame score accumulator.
package score_pkg;

  localparam int NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value representable in an unsigned field of width bw.
  function automatic logic [63:0] sat_max(input int bw);
    return (64'd1 << bw) - 64'd1;
  endfunction

endpackage

// File: rtl/score_accum10_sat_add.sv
// Unsigned saturating add of one partial score into one class accumulator.
module sat_add
  import score_pkg::*;
#(
  parameter int inW = 12,
  parameter int bW  = 17
) (
  input  logic [bW-1:0]  acc,
  input  logic [inW-1:0] in,
  output logic [bW-1:0]  sum,
  output logic           clamped
);

  localparam logic [bW-1:0] MAXV = bW'(sat_max(bW));

  logic [bW:0] wide_sum;

  // One extra bit catches the overflow; clamp to the top value when it is set.
  always_comb begin
    wide_sum = {1'b0, acc} + {{(bW + 1 - inW){1'b0}}, in};
    clamped  = wide_sum[bW];
    sum      = clamped ? MAXV : wide_sum[bW-1:0];
  end

endmodule

// File: rtl/score_accum10.sv
// Frame-based per-class score accumulator feeding the 10-way argmax stage.
// State | meaning
// IDLE  | no frame open, ready for the first beat
// ACCUM | frame open, summing beats
// DONE  | one cycle after a close, in_ready low
module score_accum10
  import score_pkg::*;
#(
  parameter int inW       = 12,
  parameter int bW        = 17,
  parameter int MAX_BEATS = 64,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [inW-1:0] in_data [0:NUM_CLASSES-1],
  input  logic           in_last,
  output logic [bW-1:0]  bids [0:NUM_CLASSES-1],
  output logic           bids_valid,
  output logic           win_valid,
  output logic [CW-1:0]  frame_beats,
  output logic           sat_frame,
  output logic           err_long
);

  if (bW < inW) begin : g_bad_width
    $error("score_accum10: bW must be >= inW");
  end

  state_e          state_q, state_d;
  logic [bW-1:0]   acc_q [NUM_CLASSES];
  logic [bW-1:0]   acc_d [NUM_CLASSES];
  logic [bW-1:0]   bids_q [NUM_CLASSES];
  logic [bW-1:0]   bids_d [NUM_CLASSES];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   frame_beats_q, frame_beats_d;
  logic            sat_flag_q, sat_flag_d;
  logic            sat_frame_q, sat_frame_d;
  logic            err_long_q, err_long_d;
  logic            in_ready_q, in_ready_d;
  logic            bids_valid_q, bids_valid_d;
  logic            win_valid_q, win_valid_d;

  logic [bW-1:0]          acc_op [NUM_CLASSES];
  logic [bW-1:0]          sum_w  [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] clamp_w;

  logic            accept;
  logic            first_beat;
  logic            close;
  logic            sat_new;
  logic [CW-1:0]   cnt_new;

  assign accept     = in_valid && in_ready_q;
  assign first_beat = (state_q == IDLE);

  // The first beat of a frame adds onto zero so stale sums never leak in.
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
    assign acc_op[i] = first_beat ? '0 : acc_q[i];
    sat_add #(.inW(inW), .bW(bW)) u_sat_add (
      .acc     (acc_op[i]),
      .in      (in_data[i]),
      .sum     (sum_w[i]),
      .clamped (clamp_w[i])
    );
  end

  // Next-state, accumulator and output-register logic.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bids_d        = bids_q;
    cnt_d         = cnt_q;
    frame_beats_d = frame_beats_q;
    sat_flag_d    = sat_flag_q;
    sat_frame_d   = sat_frame_q;
    err_long_d    = err_long_q;
    bids_valid_d  = 1'b0;
    win_valid_d   = bids_valid_q;

    cnt_new = (first_beat ? '0 : cnt_q) + CW'(1);
    sat_new = (first_beat ? 1'b0 : sat_flag_q) | (|clamp_w);
    close   = in_last || (cnt_new == CW'(MAX_BEATS));

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d      = sum_w;
          cnt_d      = cnt_new;
          sat_flag_d = sat_new;
          if (close) begin
            state_d       = DONE;
            bids_d        = sum_w;
            frame_beats_d = cnt_new;
            sat_frame_d   = sat_new;
            bids_valid_d  = 1'b1;
            if (!in_last) err_long_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != DONE);
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '{default: '0};
      bids_q        <= '{default: '0};
      cnt_q         <= '0;
      frame_beats_q <= '0;
      sat_flag_q    <= 1'b0;
      sat_frame_q   <= 1'b0;
      err_long_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      bids_valid_q  <= 1'b0;
      win_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bids_q        <= bids_d;
      cnt_q         <= cnt_d;
      frame_beats_q <= frame_beats_d;
      sat_flag_q    <= sat_flag_d;
      sat_frame_q   <= sat_frame_d;
      err_long_q    <= err_long_d;
      in_ready_q    <= in_ready_d;
      bids_valid_q  <= bids_valid_d;
      win_valid_q   <= win_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign bids        = bids_q;
  assign bids_valid  = bids_valid_q;
  assign win_valid   = win_valid_q;
  assign frame_beats = frame_beats_q;
  assign sat_frame   = sat_frame_q;
  assign err_long    = err_long_q;

endmodule

// File: tb/tb_score_accum10.sv
// Directed-vector bench for score_accum10.
module tb_score_accum10;

  localparam int NC = 10;
  localparam int IW = 12;
  localparam int BW = 17;
  localparam int MB = 64;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data [0:NC-1];
  logic          in_last;
  logic [BW-1:0] bids [0:NC-1];
  logic          bids_valid;
  logic          win_valid;
  logic [CW-1:0] frame_beats;
  logic          sat_frame;
  logic          err_long;

  int checks = 0;
  int errors = 0;

  score_accum10 #(.inW(IW), .bW(BW), .MAX_BEATS(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .bids        (bids),
    .bids_valid  (bids_valid),
    .win_valid   (win_valid),
    .frame_beats (frame_beats),
    .sat_frame   (sat_frame),
    .err_long    (err_long)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NC; i++) in_data[i] = IW'(v);
  endtask

  // Offer one beat, wait (bounded) for in_ready, return just after acceptance.
  task automatic do_beat(input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL beat_wait: in_ready never rose within 20 cycles");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; set_all(0);
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < NC; i++) if (bids[i] !== '0) bad++;
    checks++;
    if (bad != 0 || bids_valid !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_bids: nonzero bids=%0d bv=%b wv=%b required 0 0 0", bad, bids_valid, win_valid);
    end
    checks++;
    if (frame_beats !== '0 || sat_frame !== 1'b0 || err_long !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: fb=%0d sat=%b err=%b rdy=%b required 0 0 0 0", frame_beats, sat_frame, err_long, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_pre: got %b required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_post: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int bad;
    for (int i = 0; i < NC; i++) in_data[i] = IW'(i + 1);
    do_beat(1'b0);
    do_beat(1'b0);
    do_beat(1'b1);
    bad = 0;
    for (int i = 0; i < NC; i++) if (bids[i] !== BW'(3 * (i + 1))) bad++;
    checks++;
    if (bad != 0 || bids[9] !== BW'(30)) begin
      errors++; $display("FAIL basic_bids: %0d wrong, bids[9]=%0d required 30", bad, bids[9]);
    end
    checks++;
    if (frame_beats !== CW'(3) || bids_valid !== 1'b1 || win_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_close: fb=%0d bv=%b wv=%b rdy=%b required 3 1 0 0", frame_beats, bids_valid, win_valid, in_ready);
    end
    step();
    checks++;
    if (bids_valid !== 1'b0 || win_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_win: bv=%b wv=%b rdy=%b required 0 1 1", bids_valid, win_valid, in_ready);
    end
    step();
    checks++;
    if (win_valid !== 1'b0 || sat_frame !== 1'b0) begin
      errors++; $display("FAIL basic_win_end: wv=%b sat=%b required 0 0", win_valid, sat_frame);
    end
  endtask

  task automatic test_saturation();
    set_all(0);
    in_data[2] = 12'd4095;
    for (int b = 1; b <= 40; b++) do_beat(b == 40);
    checks++;
    if (bids[2] !== 17'd131071 || sat_frame !== 1'b1) begin
      errors++; $display("FAIL sat_bid: bids[2]=%0d sat=%b required 131071 1", bids[2], sat_frame);
    end
    checks++;
    if (bids[0] !== '0 || bids[3] !== '0 || bids[9] !== '0 || frame_beats !== CW'(40)) begin
      errors++;
      $display("FAIL sat_others: b0=%0d b3=%0d b9=%0d fb=%0d required 0 0 0 40", bids[0], bids[3], bids[9], frame_beats);
    end
    step();
  endtask

  task automatic test_long();
    set_all(1);
    for (int b = 1; b <= 64; b++) do_beat(1'b0);
    checks++;
    if (bids_valid !== 1'b1 || err_long !== 1'b1 || frame_beats !== CW'(64) || bids[0] !== BW'(64)) begin
      errors++;
      $display("FAIL long_close: bv=%b err=%b fb=%0d b0=%0d required 1 1 64 64", bids_valid, err_long, frame_beats, bids[0]);
    end
    checks++;
    if (sat_frame !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL long_flags: sat=%b rdy=%b required 0 0", sat_frame, in_ready);
    end
    for (int b = 65; b <= 70; b++) do_beat(1'b0);
    do_beat(1'b1);
    checks++;
    if (frame_beats !== CW'(7) || bids[5] !== BW'(7) || err_long !== 1'b1) begin
      errors++;
      $display("FAIL long_next: fb=%0d b5=%0d err=%b required 7 7 1", frame_beats, bids[5], err_long);
    end
    step();
  endtask

  task automatic test_back_to_back();
    set_all(5);
    in_valid = 1'b1; in_last = 1'b0;
    step();
    in_last = 1'b1;
    step();
    checks++;
    if (bids[0] !== BW'(10) || in_ready !== 1'b0 || frame_beats !== CW'(2)) begin
      errors++; $display("FAIL b2b_first: b0=%0d rdy=%b fb=%0d required 10 0 2", bids[0], in_ready, frame_beats);
    end
    set_all(3);
    in_last = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || bids_valid !== 1'b0 || bids[0] !== BW'(10)) begin
      errors++; $display("FAIL b2b_gap: rdy=%b bv=%b b0=%0d required 1 0 10", in_ready, bids_valid, bids[0]);
    end
    step();
    in_last = 1'b1;
    step();
    checks++;
    if (bids[0] !== BW'(6) || bids[9] !== BW'(6) || frame_beats !== CW'(2) || in_ready !== 1'b0 || bids_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: b0=%0d b9=%0d fb=%0d rdy=%b bv=%b required 6 6 2 0 1", bids[0], bids[9], frame_beats, in_ready, bids_valid);
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
  endtask

  task automatic test_gaps();
    int bad;
    for (int i = 0; i < NC; i++) in_data[i] = IW'(i + 2);
    for (int b = 1; b <= 4; b++) begin
      do_beat(b == 4);
      if (b < 4) begin
        for (int i = 0; i < NC; i++) in_data[i] = IW'(12'hABC);
        repeat (5) step();
        checks++;
        if (bids_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL gap_open: beat %0d bv=%b rdy=%b required 0 1", b, bids_valid, in_ready);
        end
        for (int i = 0; i < NC; i++) in_data[i] = IW'(i + 2);
      end
    end
    bad = 0;
    for (int i = 0; i < NC; i++) if (bids[i] !== BW'(4 * (i + 2))) bad++;
    checks++;
    if (bad != 0 || frame_beats !== CW'(4) || bids_valid !== 1'b1) begin
      errors++; $display("FAIL gap_sums: %0d wrong, fb=%0d bv=%b required 0 4 1", bad, frame_beats, bids_valid);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int bad;
    set_all(9);
    do_beat(1'b0);
    do_beat(1'b0);
    rst_n = 1'b0;
    step();
    step();
    bad = 0;
    for (int i = 0; i < NC; i++) if (bids[i] !== '0) bad++;
    checks++;
    if (bad != 0 || frame_beats !== '0 || err_long !== 1'b0 || sat_frame !== 1'b0 || in_ready !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_zero: %0d bids nonzero fb=%0d err=%b sat=%b rdy=%b wv=%b required all 0", bad, frame_beats, err_long, sat_frame, in_ready, win_valid);
    end
    rst_n = 1'b1;
    set_all(7);
    do_beat(1'b1);
    bad = 0;
    for (int i = 0; i < NC; i++) if (bids[i] !== BW'(7)) bad++;
    checks++;
    if (bad != 0 || frame_beats !== CW'(1) || err_long !== 1'b0 || bids_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_frame: %0d wrong, fb=%0d err=%b bv=%b required 0 1 0 1", bad, frame_beats, err_long, bids_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_long();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
